// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, streamer states and lane helpers shared by segmented_data_memory
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} str_state_e;

  // Size 3 falls through to word behaviour in all helpers.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lane);
    return sz == SZ_BYTE ? 4'b0001 << lane : sz == SZ_HALF ? 4'b0011 << lane : 4'b1111;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lane);
    return sz == SZ_BYTE ? 1'b0 : sz == SZ_HALF ? lane[0] : |lane;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic sx);
    logic [31:0] s;
    s = w >> {lane, 3'b000};
    return sz == SZ_BYTE ? {{24{sx & s[7]}}, s[7:0]} :
           sz == SZ_HALF ? {{16{sx & s[15]}}, s[15:0]} : w;
  endfunction
endpackage

// File: rtl/dmem_str_streamer.sv
// dmem_str_streamer: walks a NUL-terminated string through a registered byte-read port,
// emitting one character per valid/ready transfer.
module dmem_str_streamer
  import dmem_pkg::*;
#(
  parameter int MAX_STR = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_str_start,
  input  logic [31:0] i_str_addr,
  input  logic        i_str_ready,
  output logic [7:0]  o_str_char,
  output logic        o_str_valid,
  output logic        o_str_busy,
  output logic        o_str_done,
  output logic        o_fault,
  output logic [31:0] o_br_addr,
  input  logic [7:0]  i_br_data,
  input  logic        i_br_ok
);
  localparam int CW = $clog2(MAX_STR + 1);
  str_state_e r_state, w_nxt;
  // Bit 32 records a carry out of the address space so a wrapped pointer is never in range.
  logic [32:0] r_ptr, w_ptr_nxt;
  logic [CW-1:0] r_cnt;
  logic [7:0] r_char;
  logic r_start_d, r_fault, w_rise, w_ok;

  assign w_rise = i_str_start & ~r_start_d;
  assign w_ok = i_br_ok & ~r_ptr[32];

  // The byte port is addressed with the next pointer so its data is ready in FETCH.
  always_comb begin
    w_nxt = r_state;
    w_ptr_nxt = r_ptr;
    case (r_state)
      IDLE: if (w_rise) begin
        w_nxt = FETCH;
        w_ptr_nxt = {1'b0, i_str_addr};
      end
      FETCH: w_nxt = (!w_ok || i_br_data == 8'h00) ? DONE : EMIT;
      EMIT: if (i_str_ready) begin
        w_ptr_nxt = r_ptr + 33'd1;
        w_nxt = r_cnt == CW'(MAX_STR - 1) ? DONE : FETCH;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_cnt <= '0;
      r_char <= '0;
      r_start_d <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_ptr <= w_ptr_nxt;
      r_start_d <= i_str_start;
      r_fault <= r_state == FETCH && !w_ok;
      if (r_state == IDLE) r_cnt <= '0;
      else if (r_state == EMIT && i_str_ready) r_cnt <= r_cnt + 1'b1;
      if (r_state == FETCH) r_char <= i_br_data;
    end

  assign o_str_char = r_char;
  assign o_str_valid = r_state == EMIT;
  assign o_str_busy = r_state != IDLE;
  assign o_str_done = r_state == DONE;
  assign o_fault = r_fault;
  assign o_br_addr = w_ptr_nxt[31:0];
endmodule

// File: rtl/segmented_data_memory.sv
// segmented_data_memory: MIPS data/stack memory with sized loads/stores and a syscall string streamer.
// Define DMEM_TRACE_EN for simulation-only store and fault messages.
module segmented_data_memory
  import dmem_pkg::*;
#(
  parameter logic [31:0] DATA_BASE   = 32'h0040_0000,
  parameter int          DATA_WORDS  = 1024,
  parameter logic [31:0] STACK_BASE  = 32'hFFFF_F000,
  parameter int          STACK_WORDS = 1024,
  parameter string       INIT_FILE   = "hello.v",
  parameter int          MAX_STR     = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [1:0]  i_size,
  input  logic        i_sign_ext,
  input  logic [31:0] i_a,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_rd,
  output logic        o_rd_valid,
  output logic        o_fault,
  input  logic        i_str_start,
  input  logic [31:0] i_str_addr,
  output logic [7:0]  o_str_char,
  output logic        o_str_valid,
  input  logic        i_str_ready,
  output logic        o_str_busy,
  output logic        o_str_done
);
  localparam int DAW = $clog2(DATA_WORDS);
  localparam int SAW = $clog2(STACK_WORDS);
  logic [31:0] r_dmem [DATA_WORDS];
  logic [31:0] r_smem [STACK_WORDS];
  logic [31:0] w_doff, w_soff, w_bdoff, w_bsoff, w_word, w_bword, w_wdata, w_br_addr, r_rd;
  logic [7:0] r_br_byte;
  logic [3:0] w_mask;
  logic w_in_d, w_in_s, w_bin_d, w_bin_s, w_fault, w_str_fault, r_br_ok, r_rd_valid, r_fault;

  // Offsets wrap below the base, so one unsigned compare covers both segment bounds.
  assign w_doff = i_a - DATA_BASE;
  assign w_soff = i_a - STACK_BASE;
  assign w_in_d = w_doff < 32'(4 * DATA_WORDS);
  assign w_in_s = w_soff < 32'(4 * STACK_WORDS);
  assign w_fault = misaligned(i_size, i_a[1:0]) | ~(w_in_d | w_in_s);
  assign w_mask = lane_mask(i_size, i_a[1:0]);
  assign w_wdata = i_write_data << {i_a[1:0], 3'b000};
  assign w_word = w_in_d ? r_dmem[w_doff[DAW+1:2]] : r_smem[w_soff[SAW+1:2]];

  assign w_bdoff = w_br_addr - DATA_BASE;
  assign w_bsoff = w_br_addr - STACK_BASE;
  assign w_bin_d = w_bdoff < 32'(4 * DATA_WORDS);
  assign w_bin_s = w_bsoff < 32'(4 * STACK_WORDS);
  assign w_bword = w_bin_d ? r_dmem[w_bdoff[DAW+1:2]] : r_smem[w_bsoff[SAW+1:2]];

  always_ff @(posedge i_clk)
    if (i_mem_write && !w_fault)
      for (int i = 0; i < 4; i++)
        if (w_mask[i]) begin
          if (w_in_d) r_dmem[w_doff[DAW+1:2]][8*i +: 8] <= w_wdata[8*i +: 8];
          else r_smem[w_soff[SAW+1:2]][8*i +: 8] <= w_wdata[8*i +: 8];
        end

  // Both read ports sample the array before any same-edge store lands.
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_rd <= '0;
      r_rd_valid <= 1'b0;
      r_fault <= 1'b0;
      r_br_byte <= '0;
      r_br_ok <= 1'b0;
    end else begin
      r_rd_valid <= i_mem_read;
      r_rd <= i_mem_read && !w_fault ? load_extract(w_word, i_size, i_a[1:0], i_sign_ext) : '0;
      r_fault <= (i_mem_read | i_mem_write) & w_fault;
      r_br_byte <= w_bword[{w_br_addr[1:0], 3'b000} +: 8];
      r_br_ok <= w_bin_d | w_bin_s;
    end

  dmem_str_streamer #(.MAX_STR(MAX_STR)) u_str (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_str_start(i_str_start),
    .i_str_addr (i_str_addr),
    .i_str_ready(i_str_ready),
    .o_str_char (o_str_char),
    .o_str_valid(o_str_valid),
    .o_str_busy (o_str_busy),
    .o_str_done (o_str_done),
    .o_fault    (w_str_fault),
    .o_br_addr  (w_br_addr),
    .i_br_data  (r_br_byte),
    .i_br_ok    (r_br_ok)
  );

  assign o_rd = r_rd;
  assign o_rd_valid = r_rd_valid;
  assign o_fault = r_fault | w_str_fault;

`ifdef DMEM_TRACE_EN
  always_ff @(posedge i_clk) begin
    if (i_mem_write && !w_fault) $display("%0t dmem store a=%h mask=%b data=%h", $time, i_a, w_mask, w_wdata);
    if (o_fault) $display("%0t dmem segment overflow", $time);
  end
`else
`endif
endmodule
